pong_vga_renderer: RTL and testbench

Consumer end of the pong game-state interface. Takes the ball and paddle positions produced by the game logic and generates a 640x480@60 VGA raster: sync timing, per-pixel colour, and a once-per-frame tick. Inputs are sampled once per frame, at the start of vertical blanking, so every displayed frame is tear-free. It sits between the pong game core and the TinyTapeout VGA PMOD output pins.

---
 rtl/pong_vga_renderer_pkg.sv | 29 ++
 rtl/pong_vga_renderer_if.sv | 21 ++
 rtl/pong_vga_renderer_timing.sv | 36 +++
 rtl/pong_vga_renderer.sv | 92 +++++++++
 tb/tb_pong_vga_renderer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pong_vga_renderer_pkg.sv
// Shared constants for the pong VGA renderer: 640x480@60 raster timing and palette.
// Sync start/end and totals are derived from the porch widths so the two stay consistent.
package pong_pkg;

    localparam int H_VISIBLE    = 640;
    localparam int H_FRONT      = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BACK       = 48;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int H_TOTAL      = H_SYNC_END + H_BACK;

    localparam int V_VISIBLE    = 480;
    localparam int V_FRONT      = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BACK       = 33;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int V_TOTAL      = V_SYNC_END + V_BACK;

    typedef logic [5:0] rgb_t;

    localparam rgb_t COL_BALL = 6'b111111;
    localparam rgb_t COL_LPAD = 6'b001111;
    localparam rgb_t COL_RPAD = 6'b110011;
    localparam rgb_t COL_NET  = 6'b010101;
    localparam rgb_t COL_BG   = 6'b000000;

endpackage

// File: rtl/pong_vga_renderer_if.sv
// Game-state link between the pong core (master) and the renderer (slave).
// The core drives positions and advances its state on frame_tick.
interface pong_vga_renderer_if;

    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] paddle_y;
    logic [9:0] opponent_y;
    logic       frame_tick;

    modport master (
        output ball_x, ball_y, paddle_y, opponent_y,
        input  frame_tick
    );

    modport slave (
        input  ball_x, ball_y, paddle_y, opponent_y,
        output frame_tick
    );

endinterface

// File: rtl/pong_vga_renderer_timing.sv
// Raster counters for the VGA scan plus raw (unregistered) sync, visible and
// vblank-start decodes; the renderer registers these alongside the pixel colour.
module vga_timing
    import pong_pkg::*;
#(
    parameter int H_VIS = H_VISIBLE,
    parameter int V_VIS = V_VISIBLE
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       visible,
    output logic       vblank_start
);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == 10'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign hsync_raw    = !((h_cnt >= 10'(H_SYNC_START)) && (h_cnt < 10'(H_SYNC_END)));
    assign vsync_raw    = !((v_cnt >= 10'(V_SYNC_START)) && (v_cnt < 10'(V_SYNC_END)));
    assign visible      = (h_cnt < 10'(H_VIS)) && (v_cnt < 10'(V_VIS));
    assign vblank_start = (h_cnt == 10'd0) && (v_cnt == 10'(V_VIS));

endmodule

// File: rtl/pong_vga_renderer.sv
// Pong raster renderer: snapshots game positions at vblank start and paints ball,
// paddles and dashed net with a fixed priority; all outputs registered one cycle after the counters.
module pong_vga_renderer
    import pong_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int BALL_SIZE     = 10,
    parameter int PADDLE_WIDTH  = 10,
    parameter int PADDLE_HEIGHT = 60,
    parameter int NET_X         = 318
) (
    input  logic                 clk,
    input  logic                 rst,
    pong_vga_renderer_if.slave   gs,
    output logic                 hsync,
    output logic                 vsync,
    output rgb_t                 rgb,
    output logic                 de
);

    logic [9:0] h_cnt, v_cnt;
    logic       hsync_raw, vsync_raw, visible, vblank_start;

    vga_timing #(
        .H_VIS (SCREEN_WIDTH),
        .V_VIS (SCREEN_HEIGHT)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .hsync_raw    (hsync_raw),
        .vsync_raw    (vsync_raw),
        .visible      (visible),
        .vblank_start (vblank_start)
    );

    logic [9:0] sb_x, sb_y, sp_y, so_y;

    // Comparisons are done 11 bits wide so position+size cannot wrap back to the top/left.
    logic [10:0] h11, v11;
    logic        ball_hit, lpad_hit, rpad_hit, net_hit;
    rgb_t        pix_rgb;

    assign h11 = {1'b0, h_cnt};
    assign v11 = {1'b0, v_cnt};

    always_comb begin
        ball_hit = (h11 >= {1'b0, sb_x}) && (h11 < {1'b0, sb_x} + 11'(BALL_SIZE)) &&
                   (v11 >= {1'b0, sb_y}) && (v11 < {1'b0, sb_y} + 11'(BALL_SIZE));
        lpad_hit = (h11 < 11'(PADDLE_WIDTH)) &&
                   (v11 >= {1'b0, sp_y}) && (v11 < {1'b0, sp_y} + 11'(PADDLE_HEIGHT));
        rpad_hit = (h11 >= 11'(SCREEN_WIDTH - PADDLE_WIDTH)) &&
                   (v11 >= {1'b0, so_y}) && (v11 < {1'b0, so_y} + 11'(PADDLE_HEIGHT));
        net_hit  = (h11 >= 11'(NET_X)) && (h11 < 11'(NET_X + 4)) && !v_cnt[3];

        pix_rgb = COL_BG;
        if (ball_hit)      pix_rgb = COL_BALL;
        else if (lpad_hit) pix_rgb = COL_LPAD;
        else if (rpad_hit) pix_rgb = COL_RPAD;
        else if (net_hit)  pix_rgb = COL_NET;
    end

    // Output stage: everything here is one cycle behind (h_cnt, v_cnt).
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_x          <= '0;
            sb_y          <= '0;
            sp_y          <= '0;
            so_y          <= '0;
            hsync         <= 1'b1;
            vsync         <= 1'b1;
            rgb           <= COL_BG;
            de            <= 1'b0;
            gs.frame_tick <= 1'b0;
        end else begin
            if (vblank_start) begin
                sb_x <= gs.ball_x;
                sb_y <= gs.ball_y;
                sp_y <= gs.paddle_y;
                so_y <= gs.opponent_y;
            end
            hsync         <= hsync_raw;
            vsync         <= vsync_raw;
            rgb           <= visible ? pix_rgb : COL_BG;
            de            <= visible;
            gs.frame_tick <= vblank_start;
        end
    end

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Directed bench for pong_vga_renderer: a pixel-indexed vector table walks three
// frames, with hand-written sequences for reset, an hsync line scan and a mid-frame input change.
module tb_pong_vga_renderer;

    localparam int LINE  = 800;
    localparam int FRAME = 420000;

    logic       clk = 1'b0;
    logic       rst;
    logic       hsync, vsync, de;
    logic [5:0] rgb;
    int         pix;
    int         n_chk  = 0;
    int         n_pass = 0;

    pong_vga_renderer_if gs ();

    pong_vga_renderer dut (
        .clk   (clk),
        .rst   (rst),
        .gs    (gs),
        .hsync (hsync),
        .vsync (vsync),
        .rgb   (rgb),
        .de    (de)
    );

    always #5 clk = ~clk;

    // Index of the pixel whose outputs are currently presented (-1 while in reset).
    always @(posedge clk) pix <= rst ? -1 : pix + 1;

    initial begin
        repeat (1300000) @(posedge clk);
        $display("FAIL watchdog: run did not end, pix=%0d", pix);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int         x;
        int         y;
        int         f;
        logic [5:0] rgb;
        logic       ft;
        int         act;   // 0 none, 1 hsync line scan first, 2 move ball first
    } vec_t;

    vec_t tab[$];

    task automatic add(input int x, input int y, input int f, input logic [5:0] c,
                       input logic ft, input int act);
        vec_t v;
        v.x = x; v.y = y; v.f = f; v.rgb = c; v.ft = ft; v.act = act;
        tab.push_back(v);
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    task automatic at_pixel(input int x, input int y, input int f);
        int target;
        target = f * FRAME + y * LINE + x;
        while (pix < target) @(negedge clk);
        if (pix != target) begin
            n_chk++;
            $display("FAIL sync: at pixel %0d, want %0d", pix, target);
        end
    endtask

    function automatic logic [2:0] sync_exp(input int x, input int y);
        logic d, h, v;
        d = (x < 640) && (y < 480);
        h = !((x >= 656) && (x < 752));
        v = !((y >= 490) && (y < 492));
        return {d, h, v};
    endfunction

    task automatic check_vec(input vec_t v);
        logic [9:0] got, want;
        got  = {rgb, de, hsync, vsync, gs.frame_tick};
        want = {v.rgb, sync_exp(v.x, v.y), v.ft};
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL px(%0d,%0d,f%0d): got rgb/de/hs/vs/ft=%b/%b/%b/%b/%b, want %b/%b/%b/%b/%b",
                      v.x, v.y, v.f, got[9:4], got[3], got[2], got[1], got[0],
                      want[9:4], want[3], want[2], want[1], want[0]);
    endtask

    task automatic line_scan(input int y);
        int lows, first;
        lows = 0; first = -1;
        at_pixel(0, y, 0);
        for (int i = 0; i < LINE; i++) begin
            if (!hsync) begin
                if (first < 0) first = i;
                lows++;
            end
            @(negedge clk);
        end
        chk("hsync_low_len", lows, 96);
        chk("hsync_low_start", first, 656);
    endtask

    initial begin
        // Frame 0 draws from reset shadows: everything at (0,0).
        add(0,   0,   0, 6'b111111, 0, 0);
        add(318, 0,   0, 6'b010101, 0, 0);
        add(322, 0,   0, 6'b000000, 0, 0);
        add(629, 0,   0, 6'b000000, 0, 0);
        add(630, 0,   0, 6'b110011, 0, 0);
        add(639, 0,   0, 6'b110011, 0, 0);
        add(640, 0,   0, 6'b000000, 0, 0);
        add(655, 1,   0, 6'b000000, 0, 0);
        add(656, 1,   0, 6'b000000, 0, 0);
        add(751, 1,   0, 6'b000000, 0, 0);
        add(752, 1,   0, 6'b000000, 0, 0);
        add(5,   5,   0, 6'b111111, 0, 0);
        add(10,  5,   0, 6'b000000, 0, 0);
        add(321, 7,   0, 6'b010101, 0, 0);
        add(318, 8,   0, 6'b000000, 0, 0);
        add(9,   9,   0, 6'b111111, 0, 0);
        add(318, 16,  0, 6'b010101, 0, 0);
        add(5,   20,  0, 6'b001111, 0, 0);
        add(635, 20,  0, 6'b110011, 0, 0);
        add(5,   59,  0, 6'b001111, 0, 0);
        add(5,   60,  0, 6'b000000, 0, 0);
        add(630, 60,  0, 6'b000000, 0, 0);
        add(318, 464, 0, 6'b010101, 0, 1);
        add(318, 472, 0, 6'b000000, 0, 0);
        add(799, 479, 0, 6'b000000, 0, 0);
        add(0,   480, 0, 6'b000000, 1, 0);
        add(1,   480, 0, 6'b000000, 0, 0);
        add(0,   489, 0, 6'b000000, 0, 0);
        add(0,   490, 0, 6'b000000, 0, 0);
        add(799, 491, 0, 6'b000000, 0, 0);
        add(0,   492, 0, 6'b000000, 0, 0);
        // Frame 1: ball (100,200), left paddle 470, right paddle 400.
        add(0,   0,   1, 6'b000000, 0, 0);
        add(9,   0,   1, 6'b000000, 0, 0);
        add(318, 0,   1, 6'b010101, 0, 0);
        add(99,  200, 1, 6'b000000, 0, 2);
        add(100, 200, 1, 6'b111111, 0, 0);
        add(110, 200, 1, 6'b000000, 0, 0);
        add(300, 200, 1, 6'b000000, 0, 0);
        add(109, 209, 1, 6'b111111, 0, 0);
        add(100, 210, 1, 6'b000000, 0, 0);
        add(629, 400, 1, 6'b000000, 0, 0);
        add(635, 400, 1, 6'b110011, 0, 0);
        add(635, 459, 1, 6'b110011, 0, 0);
        add(635, 460, 1, 6'b000000, 0, 0);
        add(5,   470, 1, 6'b001111, 0, 0);
        add(10,  470, 1, 6'b000000, 0, 0);
        add(9,   479, 1, 6'b001111, 0, 0);
        add(0,   480, 1, 6'b000000, 1, 0);
        add(5,   480, 1, 6'b000000, 0, 0);
        // Frame 2: ball moved to (300,200); paddle at 470 must not wrap to row 0.
        add(5,   0,   2, 6'b000000, 0, 0);
        add(100, 200, 2, 6'b000000, 0, 0);
        add(300, 200, 2, 6'b111111, 0, 0);
        add(309, 209, 2, 6'b111111, 0, 0);
        add(310, 209, 2, 6'b000000, 0, 0);
        add(5,   470, 2, 6'b001111, 0, 0);

        rst = 1'b1;
        gs.ball_x = 10'd0; gs.ball_y = 10'd0; gs.paddle_y = 10'd0; gs.opponent_y = 10'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_hsync", int'(hsync), 1);
        chk("reset_vsync", int'(vsync), 1);
        chk("reset_rgb", int'(rgb), 0);
        chk("reset_de", int'(de), 0);
        chk("reset_ft", int'(gs.frame_tick), 0);
        rst = 1'b0;
        gs.ball_x = 10'd100; gs.ball_y = 10'd200; gs.paddle_y = 10'd470; gs.opponent_y = 10'd400;

        foreach (tab[i]) begin
            if (tab[i].act == 1) line_scan(61);
            if (tab[i].act == 2) begin
                at_pixel(0, 100, 1);
                gs.ball_x = 10'd300;
            end
            at_pixel(tab[i].x, tab[i].y, tab[i].f);
            check_vec(tab[i]);
        end

        // Mid-frame reset: outputs drop immediately and shadows return to zero.
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rgb", int'(rgb), 0);
        chk("midrst_de", int'(de), 0);
        chk("midrst_hsync", int'(hsync), 1);
        chk("midrst_vsync", int'(vsync), 1);
        chk("midrst_ft", int'(gs.frame_tick), 0);
        rst = 1'b0;
        at_pixel(0, 0, 0);
        chk("post_rst_rgb00", int'(rgb), 'h3f);
        chk("post_rst_de00", int'(de), 1);
        at_pixel(5, 20, 0);
        chk("post_rst_rgb_5_20", int'(rgb), 'h0f);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
